// File: rtl/clk_div_prog_if.sv
// ---------------------------------------------------------------------------
// clk_div_prog_if
// Signal bundle for the multi-channel programmable clock divider.
//   en     [CH-1:0]   per-channel enable (driven by the controller)
//   div    [CH*W-1:0] per-channel ratio, channel c at div[c*W +: W]
//   clkdiv [CH-1:0]   divided clocks (driven by the divider)
//   tick   [CH-1:0]   one-cycle period-start strobes
//   active [CH-1:0]   channel running (mid-period)
// master: controller side, slave: divider side.
// ---------------------------------------------------------------------------
interface clk_div_prog_if #(
    parameter int CH = 2,
    parameter int W  = 8
);
    logic [CH-1:0]   en;
    logic [CH*W-1:0] div;
    logic [CH-1:0]   clkdiv;
    logic [CH-1:0]   tick;
    logic [CH-1:0]   active;

    modport master (output en, output div, input clkdiv, input tick, input active);
    modport slave  (input en, input div, output clkdiv, output tick, output active);
endinterface

// File: rtl/clk_div_prog.sv
// ---------------------------------------------------------------------------
// clk_div_prog
// Multi-channel programmable clock divider with 50 % duty for any integer
// ratio 2..2^W-1 (0 and 1 clamp to 2). Each channel latches its ratio only at
// a period boundary, so ratio changes and disables never produce runt pulses.
// Ports:
//   clk    source clock (rising edge, plus falling edge for the odd-ratio
//          half-cycle extension register)
//   rst_n  asynchronous active-low reset
//   bus    clk_div_prog_if slave: en, div in; clkdiv, tick, active out
// ---------------------------------------------------------------------------
module clk_div_prog #(
    parameter int CH = 2,
    parameter int W  = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    clk_div_prog_if.slave  bus
);

    logic [CH-1:0] clkdiv_w;
    logic [CH-1:0] tick_w;
    logic [CH-1:0] active_w;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [W-1:0] div_c;
        logic [W-1:0] n_eff;
        logic [W-1:0] half;
        logic [W:0]   cnt_inc;
        logic [W-1:0] cnt_q,  cnt_d;
        logic [W-1:0] nact_q, nact_d;
        logic         run_q,  run_d;
        logic         p_q,    p_d;
        logic         tick_q, tick_d;
        logic         n_q;
        logic         wrap;
        logic         boundary;

        assign div_c    = bus.div[c*W +: W];
        assign n_eff    = (div_c < W'(2)) ? W'(2) : div_c;
        assign half     = nact_q >> 1;
        // One extra bit so the increment and the compare never wrap at max ratio
        assign cnt_inc  = {1'b0, cnt_q} + (W+1)'(1);
        assign wrap     = run_q && (cnt_q == nact_q - W'(1));
        assign boundary = bus.en[c] && (!run_q || wrap);

        always_comb begin
            cnt_d  = cnt_q;
            nact_d = nact_q;
            run_d  = run_q;
            p_d    = p_q;
            tick_d = 1'b0;
            if (boundary) begin
                nact_d = n_eff;
                cnt_d  = '0;
                p_d    = 1'b1;
                run_d  = 1'b1;
                tick_d = 1'b1;
            end else if (wrap) begin
                // en low at the wrap edge: the period has fully completed, park
                run_d  = 1'b0;
                cnt_d  = '0;
                p_d    = 1'b0;
            end else if (run_q) begin
                cnt_d  = cnt_inc[W-1:0];
                p_d    = (cnt_inc < {1'b0, half});
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt_q  <= '0;
                nact_q <= W'(2);
                run_q  <= 1'b0;
                p_q    <= 1'b0;
                tick_q <= 1'b0;
            end else begin
                cnt_q  <= cnt_d;
                nact_q <= nact_d;
                run_q  <= run_d;
                p_q    <= p_d;
                tick_q <= tick_d;
            end
        end

        // Half-cycle delayed copy; OR-ing it in stretches the high phase by
        // half a clk period for odd ratios.
        always_ff @(negedge clk or negedge rst_n) begin
            if (!rst_n) begin
                n_q <= 1'b0;
            end else begin
                n_q <= p_q;
            end
        end

        assign clkdiv_w[c] = nact_q[0] ? (p_q | n_q) : p_q;
        assign tick_w[c]   = tick_q;
        assign active_w[c] = run_q;
    end

    assign bus.clkdiv = clkdiv_w;
    assign bus.tick   = tick_w;
    assign bus.active = active_w;

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Multi-channel programmable clock divider producing 50 %-duty divided clocks for any integer ratio, odd or even. Each channel runs from the shared input clock with its own runtime divisor, per-channel enable and a single-cycle period-start strobe in the `clk` domain. Divisor changes take effect only at a period boundary, so no output glitches and no runt pulses. The block sits next to the fixed-ratio divider and replaces it wherever the ratio must be programmable or more than one derived clock is needed.

## Interface
- `CH`, default 2: number of independent divider channels (≥1).
- `W`, default 8: divisor width; ratios 2..2^W−1.

Ports:
- `clk` input 1: source clock; all state except `n_q` on rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `en` input CH: per-channel enable, sampled on `clk` rising edge.
- `div` input CH*W: channel c ratio at `div[c*W +: W]`; sampled only at a period boundary.
- `clkdiv` output CH: divided clocks.
- `tick` output CH: one-`clk`-cycle pulse marking the start of each output period.
- `active` output CH: channel is mid-period (running).

## Operation
- Per channel:
  - `cnt` (W bits), `nact` (W bits, latched ratio), `run`, posedge register `p_q`, negedge register `n_q`.
- Effective ratio: `N = (div_c < 2) ? 2 : div_c`. 0 and 1 clamp to 2. `H = N >> 1`.
- Period boundary: a rising edge where either of these holds:
  - `run=0` and `en=1` (start).
  - `run=1` and `cnt == nact−1` and `en=1` (wrap).
- At a boundary: `nact<=N`, `cnt<=0`, `p_q<=1`, `run<=1`, `tick<=1`.
- Otherwise while `run=1`:
  - `cnt<=cnt+1`.
  - `p_q<=(cnt+1 < H)`.
  - `tick<=0`.
- `n_q` captures `p_q` on every falling edge of `clk`.
- Output:
  - `clkdiv = p_q` when `nact` is even.
  - `clkdiv = p_q | n_q` when `nact` is odd.
  - Result: high for exactly N/2 `clk` periods (half-cycle resolution), period N, rising edge aligned to a `clk` rising edge.
- Disable: when `en=0` at the wrap edge, the current period completes. At that edge `run<=0`, `cnt<=0`, `p_q<=0`, no tick, and `clkdiv` stays 0. Dropping `en` mid-period never truncates the high or low phase.
- `active = run`.
- Channels are fully independent; no shared state beyond `clk`/`rst_n`.

## Timing
- Reset (async assert, sync deassert by the integrator):
  - `cnt=0`, `nact=2`, `run=0`, `p_q=0`, `n_q=0`, `tick=0`.
  - Outputs: `clkdiv=0`, `tick=0`, `active=0`.
- Start latency:
  - With `en=1` at the first rising edge after reset release, `clkdiv` and `tick` rise at that edge's register update.
  - `tick` lasts exactly one `clk` cycle.
- Even N: `clkdiv` high for N/2 rising edges, then low for N/2.
- Odd N:
  - `p_q` is high for (N−1)/2 cycles.
  - `n_q` extends the high phase by half a cycle, giving a high phase of (N−1)/2 + 0.5 cycles.
  - Falling edge of `clkdiv` lands on a `clk` falling edge.
- Ratio change:
  - A new `div` value applies from the next boundary only.
  - Changes between boundaries, including multiple changes, are ignored except the value present at the boundary edge.
- `div` change and `en` deassert on the same wrap edge: `en` wins. The channel stops and the new ratio is latched at the next start.
- Reset mid-period: all outputs go to 0 immediately (asynchronously). The next period starts as a fresh start with the current `div`.
- Maximum ratio 2^W−1: `cnt` reaches 2^W−2, no overflow.

## Test plan
- Even ratio:
  - Stimulus: CH0 `div=4`, `en=1` after reset.
  - Required: `clkdiv` is 2 cycles high / 2 low, period 4 cycles, `tick` every 4th cycle aligned to each rising edge of `clkdiv`.
- Odd ratio:
  - Stimulus: `div=5`.
  - Required: high time 2.5 `clk` periods, period 5, measured at half-cycle resolution; `div=3` gives 1.5 high / 1.5 low.
- Runtime change:
  - Stimulus: `div` switches 4→7 mid-period.
  - Required: the current period completes at 4; the next period is 7 with 3.5 high; no pulse shorter than 2 cycles.
- Clamp:
  - Stimulus: `div=0`, then `div=1`.
  - Required: output identical to `div=2` (toggles every cycle, `tick` every 2 cycles).
- Enable and reset:
  - `en` dropped 1 cycle into an N=6 period: 3 high + 3 low completes, then `clkdiv=0`, `active=0`.
  - `rst_n` pulsed low mid-high phase: `clkdiv`, `tick`, `active` go 0 immediately.
  - Restart after reset release begins a full period.
- Multi-channel (CH=2):
  - Stimulus: ratios 3 and 8, with CH1 enabled 5 cycles later.
  - Required: each channel meets its own period and duty, with `tick` spacing 3 and 8 independently.
